// File: rtl/ds1302_pkg.sv
// ds1302_pkg: shared definitions for the DS1302 transfer engine.
//   - command-byte bit positions and burst address
//   - burst length limits for the RAM and clock register spaces
//   - request struct, FSM state enum and command helpers
package ds1302_pkg;
    localparam int CMD_BIT_CMD  = 7;   // always 1 for a valid command
    localparam int CMD_BIT_RAM  = 6;   // 1 = RAM space, 0 = clock space
    localparam int CMD_ADDR_LSB = 1;   // bits 5:1 register index
    localparam int CMD_BIT_RD   = 0;   // 1 = read, 0 = write

    localparam logic [4:0] BURST_ADDR = 5'h1F;
    localparam int MAX_RAM_LEN = 31;
    localparam int MAX_CLK_LEN = 8;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ERR, ST_SETUP, ST_CMD, ST_WDATA, ST_RDATA, ST_HOLD, ST_GAP
    } state_t;

    typedef struct packed {
        logic       write;
        logic       ram;
        logic       burst;
        logic [4:0] addr;
        logic [4:0] len;
    } req_t;

    function automatic logic [7:0] cmd_byte(req_t r);
        logic [7:0] b;
        b = '0;
        b[CMD_BIT_CMD] = 1'b1;
        b[CMD_BIT_RAM] = r.ram;
        b[CMD_ADDR_LSB +: 5] = r.burst ? BURST_ADDR : r.addr;
        b[CMD_BIT_RD] = ~r.write;
        return b;
    endfunction

    // Single-register commands are always legal; bursts must fit their space.
    function automatic logic illegal(req_t r);
        return r.burst && ((r.len == 5'd0) ||
               (int'(r.len) > (r.ram ? MAX_RAM_LEN : MAX_CLK_LEN)));
    endfunction
endpackage

// File: rtl/ds1302_xfer_if.sv
// ds1302_xfer_if: command, write-stream and read-stream signals between a
// controller (master) and the transfer engine (slave).
//   req_*            command handshake and fields
//   wr_data/valid/ready  write byte stream into the engine
//   rd_data/valid    read byte pulses out of the engine
//   done / err       end-of-transfer and rejected-command pulses
interface ds1302_xfer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic       req_ram;
    logic       req_burst;
    logic [4:0] req_addr;
    logic [4:0] req_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       err;

    modport master (
        output req_valid, req_write, req_ram, req_burst, req_addr, req_len,
               wr_data, wr_valid,
        input  req_ready, wr_ready, rd_data, rd_valid, done, err
    );

    modport slave (
        input  req_valid, req_write, req_ram, req_burst, req_addr, req_len,
               wr_data, wr_valid,
        output req_ready, wr_ready, rd_data, rd_valid, done, err
    );
endinterface

// File: rtl/ds1302_shift8.sv
// ds1302_shift8: one serial byte on the DS1302 wire, LSB first.
//   start/dir_read/tx_byte  load a byte; accepted when idle or on the done cycle
//   busy / done             done is high on the last sysclk cycle of bit 7
//   sclk, io_out, io_oe     pin drive; io_in is the sampled pin
//   rx_byte / rx_valid      completed read byte, pulse one cycle after bit 7
//                           is sampled; rx_byte holds until the next read byte
// Each bit cell is CLK_DIV cycles low then CLK_DIV cycles high.
module ds1302_shift8 #(
    parameter int CLK_DIV = 50
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir_read,
    input  logic [7:0] tx_byte,
    input  logic       io_in,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       io_out,
    output logic       io_oe,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);
    localparam int CW = $clog2(2 * CLK_DIV);

    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic          rd_mode;
    logic          last_cycle;

    assign last_cycle = busy && (cnt == CW'(2 * CLK_DIV - 1));
    assign done       = last_cycle && (bit_idx == 3'd7);
    assign sclk       = busy && (cnt >= CW'(CLK_DIV));
    assign io_out     = sh[0];
    assign io_oe      = busy && !rd_mode;

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            rd_mode  <= 1'b0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start && (!busy || done)) begin
                // Reloading on the done cycle lets bytes run back to back.
                busy    <= 1'b1;
                cnt     <= '0;
                bit_idx <= '0;
                sh      <= tx_byte;
                rd_mode <= dir_read;
            end else if (busy) begin
                // Reads sample on the last cycle of the low half.
                if (rd_mode && (cnt == CW'(CLK_DIV - 1))) begin
                    sh <= {io_in, sh[7:1]};
                    if (bit_idx == 3'd7) begin
                        rx_byte  <= {io_in, sh[7:1]};
                        rx_valid <= 1'b1;
                    end
                end
                if (last_cycle) begin
                    cnt     <= '0;
                    bit_idx <= bit_idx + 3'd1;
                    if (!rd_mode) sh <= {1'b0, sh[7:1]};
                    if (bit_idx == 3'd7) busy <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/ds1302_xfer.sv
// ds1302_xfer: DS1302 transfer engine, single or burst, clock or RAM space.
//   sysclk, rst      clock and synchronous active-low reset
//   bus              command / write-stream / read-stream (slave side)
//   ds1302_ce/sclk   device chip enable and serial clock
//   ds1302_io        bidirectional device data pin
// The FSM frames CE and sequences bytes; ds1302_shift8 moves the bits.
module ds1302_xfer
    import ds1302_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int CE_GAP  = 200
) (
    input  logic          sysclk,
    input  logic          rst,
    ds1302_xfer_if.slave  bus,
    output logic          ds1302_ce,
    output logic          ds1302_sclk,
    inout  wire           ds1302_io
);
    localparam int CMAX = (2 * CLK_DIV > CE_GAP) ? 2 * CLK_DIV : CE_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [4:0]    left;
    logic          write_q;
    logic [7:0]    cmd_q;
    req_t          req;
    logic          last_byte;
    logic          wr_ready;

    logic       sh_start, sh_rd, sh_busy, sh_done, io_out, io_oe;
    logic [7:0] sh_tx;

    assign req       = {bus.req_write, bus.req_ram, bus.req_burst,
                        bus.req_addr, bus.req_len};
    assign last_byte = (left == 5'd1);

    ds1302_shift8 #(.CLK_DIV(CLK_DIV)) u_shift (
        .sysclk   (sysclk),
        .rst      (rst),
        .start    (sh_start),
        .dir_read (sh_rd),
        .tx_byte  (sh_tx),
        .io_in    (ds1302_io),
        .busy     (sh_busy),
        .done     (sh_done),
        .sclk     (ds1302_sclk),
        .io_out   (io_out),
        .io_oe    (io_oe),
        .rx_byte  (bus.rd_data),
        .rx_valid (bus.rd_valid)
    );

    assign ds1302_io     = io_oe ? io_out : 1'bz;
    assign ds1302_ce     = state inside {ST_SETUP, ST_CMD, ST_WDATA, ST_RDATA, ST_HOLD};
    assign bus.req_ready = (state == ST_IDLE) && rst;
    assign bus.err       = (state == ST_ERR);
    assign bus.done      = (state == ST_GAP) && (cnt == '0);
    assign bus.wr_ready  = wr_ready;

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            left    <= '0;
            write_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state <= state_n;
            // cnt is the number of cycles already spent in the current state.
            cnt   <= (state_n != state) ? '0 : cnt + CW'(1);
            if (state == ST_IDLE && bus.req_valid) begin
                write_q <= req.write;
                cmd_q   <= cmd_byte(req);
                left    <= req.burst ? req.len : 5'd1;
            end else if (sh_done && (state == ST_WDATA || state == ST_RDATA)) begin
                left <= left - 5'd1;
            end
        end
    end

    // Next byte is started on the shifter's done cycle so bit cells abut.
    always_comb begin
        state_n  = state;
        sh_start = 1'b0;
        sh_rd    = 1'b0;
        sh_tx    = bus.wr_data;
        wr_ready = 1'b0;
        case (state)
            ST_IDLE:
                if (bus.req_valid) state_n = illegal(req) ? ST_ERR : ST_SETUP;
            ST_ERR:
                state_n = ST_IDLE;
            ST_SETUP:
                if (cnt == CW'(2 * CLK_DIV - 1)) begin
                    sh_start = 1'b1;
                    sh_tx    = cmd_q;
                    state_n  = ST_CMD;
                end
            ST_CMD:
                if (sh_done) begin
                    if (write_q) begin
                        wr_ready = 1'b1;
                        sh_start = bus.wr_valid;
                        state_n  = ST_WDATA;
                    end else begin
                        sh_start = 1'b1;
                        sh_rd    = 1'b1;
                        state_n  = ST_RDATA;
                    end
                end
            ST_WDATA:
                if (sh_done && last_byte) begin
                    state_n = ST_HOLD;
                end else if (sh_done || !sh_busy) begin
                    // Without wr_valid the shifter idles: sclk low, ce high.
                    wr_ready = 1'b1;
                    sh_start = bus.wr_valid;
                end
            ST_RDATA:
                if (sh_done) begin
                    if (last_byte) begin
                        state_n = ST_HOLD;
                    end else begin
                        sh_start = 1'b1;
                        sh_rd    = 1'b1;
                    end
                end
            ST_HOLD:
                if (cnt == CW'(CLK_DIV - 1)) state_n = ST_GAP;
            ST_GAP:
                if (cnt == CW'(CE_GAP - 1)) state_n = ST_IDLE;
            default:
                state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ds1302_xfer.sv
// tb_ds1302_xfer: directed bench for ds1302_xfer with a DS1302 pin model.
// CLK_DIV=2, CE_GAP=4. The io line has a pull-up so a released pin reads 1.
module tb_ds1302_xfer;
    logic sysclk = 1'b0;
    logic rst    = 1'b0;
    wire  ds1302_ce, ds1302_sclk, ds1302_io;

    always #5 sysclk = ~sysclk;

    ds1302_xfer_if bus();

    ds1302_xfer #(.CLK_DIV(2), .CE_GAP(4)) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .bus         (bus),
        .ds1302_ce   (ds1302_ce),
        .ds1302_sclk (ds1302_sclk),
        .ds1302_io   (ds1302_io)
    );

    // ---------------- device model ----------------
    logic       dev_oe = 1'b0;
    logic       dev_bit = 1'b0;
    logic [7:0] cmd_sh = '0;
    logic [7:0] last_cmd = '0;
    logic [7:0] wb = '0;
    logic [7:0] wr_log [64];
    logic [7:0] rd_vals [8];
    int         bitcnt = 0;
    int         rises = 0;
    int         wr_n = 0;

    assign ds1302_io = dev_oe ? dev_bit : 1'bz;
    pullup (ds1302_io);

    always @(posedge ds1302_sclk or negedge ds1302_sclk or negedge ds1302_ce) begin
        if (!ds1302_ce) begin
            bitcnt = 0;
            dev_oe = 1'b0;
        end else if (ds1302_sclk) begin
            rises++;
            if (bitcnt < 8) begin
                cmd_sh[bitcnt] = ds1302_io;
            end else if (!cmd_sh[0]) begin
                wb[(bitcnt - 8) % 8] = ds1302_io;
                if ((bitcnt - 8) % 8 == 7) begin
                    wr_log[wr_n % 64] = wb;
                    wr_n++;
                end
            end
            bitcnt++;
            if (bitcnt == 8) last_cmd = cmd_sh;
        end else if (bitcnt >= 8 && cmd_sh[0]) begin
            dev_oe  = 1'b1;
            dev_bit = rd_vals[((bitcnt - 8) / 8) % 8][(bitcnt - 8) % 8];
        end
    end

    // ---------------- output monitor ----------------
    int         cyc = 0, acc_cyc = 0, done_cyc = 0;
    int         done_cnt = 0, err_cnt = 0, ce_cyc = 0, ce_rise = 0, both = 0;
    int         rd_n = 0;
    logic [7:0] rd_log [64];
    logic       ce_prev = 1'b0;

    always @(negedge sysclk) begin
        cyc++;
        if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        if (bus.err) err_cnt++;
        if (bus.done && bus.err) both++;
        if (bus.rd_valid) begin rd_log[rd_n % 64] = bus.rd_data; rd_n++; end
        if (ds1302_ce) ce_cyc++;
        if (ds1302_ce && !ce_prev) ce_rise++;
        ce_prev = ds1302_ce;
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0, n_fail = 0;
    int b_done, b_err, b_rd, b_wr, b_rise, b_ce, b_cer;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    task automatic snap();
        b_done = done_cnt; b_err = err_cnt; b_rd = rd_n; b_wr = wr_n;
        b_rise = rises; b_ce = ce_cyc; b_cer = ce_rise;
    endtask

    task automatic send(input logic w, input logic ram, input logic burst,
                        input logic [4:0] addr, input logic [4:0] len);
        int k;
        @(posedge sysclk); #1;
        bus.req_write = w; bus.req_ram = ram; bus.req_burst = burst;
        bus.req_addr = addr; bus.req_len = len; bus.req_valid = 1'b1;
        k = 0;
        @(negedge sysclk);
        while (!bus.req_ready && k < 10000) begin @(negedge sysclk); k++; end
        @(posedge sysclk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            tick();
            if (done_cnt > b_done) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
        for (int k = 0; k < 100 && !bus.req_ready; k++) tick();
    endtask

    task automatic wait_wr_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge sysclk);
            if (bus.wr_ready) ok = 1'b1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        bit stall_bad;
        logic [7:0] exp_b;

        bus.req_valid = 0; bus.req_write = 0; bus.req_ram = 0; bus.req_burst = 0;
        bus.req_addr = 0; bus.req_len = 0; bus.wr_data = 0; bus.wr_valid = 0;
        for (int i = 0; i < 8; i++) rd_vals[i] = '0;

        repeat (3) @(posedge sysclk);
        #1 rst = 1'b1;
        tick();
        chk("rst_ce", 32'(ds1302_ce), 0);
        chk("rst_sclk", 32'(ds1302_sclk), 0);
        chk("rst_io_released", 32'(ds1302_io), 1);
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);

        // Single write, clock register 0, data 0x45.
        snap();
        bus.wr_data = 8'h45; bus.wr_valid = 1'b1;
        send(1, 0, 0, 5'd0, 5'd0);
        wait_done("sw_timeout");
        bus.wr_valid = 1'b0;
        chk("sw_cmd", 32'(last_cmd), 32'h80);
        chk("sw_nbytes", 32'(wr_n - b_wr), 1);
        chk("sw_byte", 32'(wr_log[b_wr % 64]), 32'h45);
        chk("sw_rises", 32'(rises - b_rise), 16);
        chk("sw_done_cnt", 32'(done_cnt - b_done), 1);
        chk("sw_done_latency", 32'(done_cyc - acc_cyc), 71);
        chk("sw_ce_cycles", 32'(ce_cyc - b_ce), 70);
        chk("sw_no_err", 32'(err_cnt - b_err), 0);

        // Single read, clock register 1, device returns 0x59.
        snap();
        rd_vals[0] = 8'h59;
        send(0, 0, 0, 5'd1, 5'd0);
        wait_done("sr_timeout");
        chk("sr_cmd", 32'(last_cmd), 32'h83);
        chk("sr_rd_cnt", 32'(rd_n - b_rd), 1);
        chk("sr_rd_byte", 32'(rd_log[b_rd % 64]), 32'h59);
        chk("sr_rd_hold", 32'(bus.rd_data), 32'h59);
        chk("sr_done_cnt", 32'(done_cnt - b_done), 1);
        chk("sr_done_latency", 32'(done_cyc - acc_cyc), 71);

        // RAM burst write of 31 bytes with a stall before byte 5.
        snap();
        stall_bad = 1'b0;
        bus.wr_data = 8'h30; bus.wr_valid = 1'b1;
        send(1, 1, 1, 5'd0, 5'd31);
        for (int i = 0; i < 31; i++) begin
            bus.wr_data = 8'(8'h30 + i * 5);
            if (i == 4) begin
                wait_wr_ready(ok);
                chk("bw_stall_reach", 32'(ok), 1);
                for (int k = 0; k < 20; k++) begin
                    @(negedge sysclk);
                    if (ds1302_sclk || !ds1302_ce) stall_bad = 1'b1;
                end
                @(posedge sysclk); #1;
                bus.wr_valid = 1'b1;
            end
            wait_wr_ready(ok);
            @(posedge sysclk); #1;
            if (i == 3) bus.wr_valid = 1'b0;
        end
        wait_done("bw_timeout");
        bus.wr_valid = 1'b0;
        chk("bw_cmd", 32'(last_cmd), 32'hFE);
        chk("bw_stall_pins", 32'(stall_bad), 0);
        chk("bw_nbytes", 32'(wr_n - b_wr), 31);
        for (int i = 0; i < 31; i++) begin
            exp_b = 8'(8'h30 + i * 5);
            chk($sformatf("bw_byte%0d", i), 32'(wr_log[(b_wr + i) % 64]), 32'(exp_b));
        end
        chk("bw_done_cnt", 32'(done_cnt - b_done), 1);

        // Clock burst read of 8 bytes, device returns 0..7.
        snap();
        for (int i = 0; i < 8; i++) rd_vals[i] = 8'(i);
        send(0, 0, 1, 5'd0, 5'd8);
        wait_done("br_timeout");
        chk("br_cmd", 32'(last_cmd), 32'hBF);
        chk("br_rd_cnt", 32'(rd_n - b_rd), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("br_byte%0d", i), 32'(rd_log[(b_rd + i) % 64]), i);
        chk("br_done_cnt", 32'(done_cnt - b_done), 1);

        // Illegal commands: clock burst len 9, RAM burst len 0.
        snap();
        @(posedge sysclk); #1;
        bus.req_write = 0; bus.req_ram = 0; bus.req_burst = 1; bus.req_len = 5'd9;
        bus.req_valid = 1'b1;
        @(posedge sysclk); #1;
        bus.req_valid = 1'b0;
        tick();
        chk("ill9_err", 32'(bus.err), 1);
        chk("ill9_ready_low", 32'(bus.req_ready), 0);
        tick();
        chk("ill9_err_gone", 32'(bus.err), 0);
        chk("ill9_ready_back", 32'(bus.req_ready), 1);
        @(posedge sysclk); #1;
        bus.req_ram = 1; bus.req_len = 5'd0; bus.req_valid = 1'b1;
        @(posedge sysclk); #1;
        bus.req_valid = 1'b0;
        tick();
        chk("ill0_err", 32'(bus.err), 1);
        tick();
        chk("ill0_ready_back", 32'(bus.req_ready), 1);
        repeat (5) tick();
        chk("ill_err_cnt", 32'(err_cnt - b_err), 2);
        chk("ill_no_ce", 32'(ce_rise - b_cer), 0);
        chk("ill_no_done", 32'(done_cnt - b_done), 0);

        // Reset during byte 3 of a RAM burst write of zeros.
        snap();
        bus.wr_data = 8'h00; bus.wr_valid = 1'b1;
        send(1, 1, 1, 5'd0, 5'd5);
        ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            tick();
            if (bitcnt >= 27) ok = 1'b1;
        end
        chk("rs_reach", 32'(ok), 1);
        chk("rs_io_driven", 32'(ds1302_io), 0);
        rst = 1'b0;
        @(posedge sysclk); #1;
        chk("rs_ce", 32'(ds1302_ce), 0);
        chk("rs_sclk", 32'(ds1302_sclk), 0);
        chk("rs_io_released", 32'(ds1302_io), 1);
        @(posedge sysclk); #1;
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        repeat (40) tick();
        chk("rs_no_done", 32'(done_cnt - b_done), 0);
        chk("rs_nbytes", 32'(wr_n - b_wr), 2);
        chk("rs_ready", 32'(bus.req_ready), 1);

        // Following single read completes normally.
        snap();
        rd_vals[0] = 8'hA5;
        send(0, 0, 0, 5'd1, 5'd0);
        wait_done("pr_timeout");
        chk("pr_cmd", 32'(last_cmd), 32'h83);
        chk("pr_rd_cnt", 32'(rd_n - b_rd), 1);
        chk("pr_rd_byte", 32'(rd_log[b_rd % 64]), 32'hA5);
        chk("pr_done_cnt", 32'(done_cnt - b_done), 1);

        chk("err_done_overlap", 32'(both), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ds1302_xfer.md
# ds1302_xfer

Parametrised DS1302 transfer engine: executes single-register or burst (multi-byte, CE held) reads and writes to either the clock/calendar register file or the 31-byte battery-backed RAM. It adds burst mode, RAM access, configurable serial timing and streaming byte handshakes. It sits between time/RAM controllers above it and the DS1302 pins.

## Interface
- CLK_DIV, 50: sysclk cycles per SCLK half-period, ≥2.
- CE_GAP, 200: minimum sysclk cycles CE stays low between transfers, ≥1.
- sysclk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- req_valid / req_ready  in/out  1  command handshake; accepted when both high on one edge.
- req_write  in  1  1 = write, 0 = read.
- req_ram  in  1  1 = RAM space, 0 = clock space.
- req_burst  in  1  1 = burst, 0 = single register.
- req_addr  in  5  register index (single mode only).
- req_len  in  5  burst byte count, 1..31 (RAM), 1..8 (clock); ignored in single mode.
- wr_data  in  8  write byte stream; wr_valid in 1; wr_ready out 1.
- rd_data  out  8  read byte; rd_valid out 1 (one-cycle pulse, no backpressure).
- done  out  1  one-cycle pulse at end of transfer; err out 1 one-cycle pulse on rejected command.
- ds1302_ce, ds1302_sclk  out  1  device pins; ds1302_io inout 1.

## Operation
- Reset: ce=0, sclk=0, io released (Z), req_ready=1 (after reset deasserts), wr_ready=0, rd_valid=0, done=0, err=0, rd_data=0, state IDLE.
- Command byte, LSB sent first: bit7=1, bit6=req_ram, bits5:1 = req_addr (single) or 5'h1F (burst), bit0 = ~req_write.
- Illegal: burst with len=0, RAM len>31, clock len>8 → err pulse next cycle, no pin activity, back to IDLE.
- States: IDLE → SETUP (ce=1, 2·CLK_DIV cycles) → CMD (8 bits) → WDATA or RDATA (8 bits per byte, repeated len times) → HOLD (CLK_DIV cycles, sclk low, ce=1) → GAP (ce=0, CE_GAP cycles, done pulses on entry) → IDLE.
- Bit cell: low half CLK_DIV cycles then high half CLK_DIV cycles. Write/command bits driven at start of low half, held through high half.
- Read: io released at end of the 8th command bit's high half; each data bit sampled on the last sysclk cycle of its low half; bit order LSB first.
- Write bytes: wr_ready=1 on the cycle a byte is needed (start of each WDATA byte); if wr_valid=0, engine stalls with sclk low, ce high, indefinitely.
- Read bytes: rd_valid pulses the cycle after the 8th bit of each byte is sampled; rd_data holds until the next byte.
- Single mode = burst of length 1 with explicit address.
- rst low mid-transfer: next edge forces ce=0, sclk=0, io Z, IDLE; no done; GAP skipped.

## Timing
- req_ready=1 only in IDLE; drops the cycle after acceptance.
- Pin activity (ce rise) begins 1 cycle after acceptance.
- Total cycles, no stalls: 2·CLK_DIV + (8+8·len)·2·CLK_DIV + CLK_DIV + CE_GAP; done on first GAP cycle.
- Simultaneous req_valid and active transfer: command waits (not dropped).
- err and done never assert in the same cycle; at most one per command.

## Structure
- Package ds1302_pkg: command-byte bit positions, BURST_ADDR=5'h1F, MAX_RAM_LEN=31, MAX_CLK_LEN=8, state enum.
- Sub-module ds1302_shift8: 8-bit serial shifter + SCLK half-period counter, direction input, start/busy/done handshake; top FSM sequences bytes and CE.

## Test plan
- CLK_DIV=2, CE_GAP=4; single write clock reg 0 (seconds), data 8'h45 → io carries 8'h80 then 8'h45 LSB-first, 16 SCLK rises, done once, total 4+64+2+4 cycles.
- Single read req_ram=0 addr 1; device model drives 8'h59 → command 8'h83 on io, one rd_valid with rd_data=8'h59.
- RAM burst write len=31, wr_valid deasserted 20 cycles before byte 5 → command 8'hFE, sclk frozen low with ce high during stall, 31 bytes received in order by model.
- Clock burst read len=8 → command 8'hBF, eight rd_valid pulses with model values 8'h00..8'h07 in order.
- Clock burst len=9 and RAM burst len=0 → err pulse each, ce never rises, req_ready back to 1.
- rst low at byte 3 of a RAM burst → next edge ce=0, sclk=0, io Z, no done; following single read completes normally.
